// File: rtl/sub_bytes_arbiter.sv
// rtl/sub_bytes_arbiter.sv - arbitrates round-state and key-word requests onto one shared subBytes
module sub_bytes_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [127:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [31:0]  req1_word,
  output logic         req1_ready,
  output logic         rsp0_valid,
  output logic [127:0] rsp0_data,
  output logic         rsp1_valid,
  output logic [31:0]  rsp1_word
);

  logic         last_grant_q, last_grant_d;
  logic         rsp0_valid_q, rsp0_valid_d;
  logic [127:0] rsp0_data_q, rsp0_data_d;
  logic         rsp1_valid_q, rsp1_valid_d;
  logic [31:0]  rsp1_word_q, rsp1_word_d;

  logic         grant0, grant1;
  logic [127:0] sbox_in;
  logic [127:0] sbox_out;

  // Requester 1 wins when alone, under fixed priority, or when 0 was served last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req1_valid && (!req0_valid || (FIXED_PRIO != 0) || !last_grant_q)) begin
      grant1 = 1'b1;
    end else if (req0_valid) begin
      grant0 = 1'b1;
    end
  end

  assign req0_ready = grant0 & rst_n;
  assign req1_ready = grant1 & rst_n;

  always_comb begin
    sbox_in = 128'h0;
    if (req0_ready) begin
      sbox_in = req0_data;
    end else if (req1_ready) begin
      sbox_in = {96'h0, req1_word};
    end
  end

  subBytes u_sub_bytes (
    .rst_n    (rst_n),
    .text_in  (sbox_in),
    .text_out (sbox_out)
  );

  always_comb begin
    last_grant_d = last_grant_q;
    rsp0_valid_d = req0_ready;
    rsp0_data_d  = rsp0_data_q;
    rsp1_valid_d = req1_ready;
    rsp1_word_d  = rsp1_word_q;
    if (req0_ready) begin
      last_grant_d = 1'b0;
      rsp0_data_d  = sbox_out;
    end
    if (req1_ready) begin
      last_grant_d = 1'b1;
      rsp1_word_d  = sbox_out[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= 128'h0;
      rsp1_valid_q <= 1'b0;
      rsp1_word_q  <= 32'h0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_word_q  <= rsp1_word_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_word  = rsp1_word_q;

endmodule

// Combinational AES SubBytes on a 128-bit state; output forced to zero in reset.
module subBytes (
  input  logic         rst_n,
  input  logic [127:0] text_in,
  output logic [127:0] text_out
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits (255-b) bytes above bit 0, i.e. at bit offset {~b, 3'b000}.
  function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  always_comb begin
    text_out = 128'h0;
    if (rst_n) begin
      for (int i = 0; i < 16; i++) begin
        text_out[8*i +: 8] = sbox_lookup(text_in[8*i +: 8]);
      end
    end
  end

endmodule
